uart_fifo_ctrl: RTL and testbench
=================================

Name: uart_fifo_ctrl

Overview:
- Parametrised synchronous FIFO for the UART 16550 data path. Successor to the plain byte FIFO.
- Each entry carries a data word plus per-character error bits: parity, framing and break.
- Adds a programmable trigger level, sticky overrun detection, an error-in-FIFO indicator, full-with-read write acceptance, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the RX FIFO (error bits live) and the TX FIFO (error bits tied 0).

Parameters:
- DATA_WIDTH, 8, data bits per entry.
- ERR_WIDTH, 3, error bits per entry: [0] parity, [1] framing, [2] break.
- DATA_DEPTH, 16, number of entries; must be a power of 2 and >= 8.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- CW, clog2(DATA_DEPTH)+1, count width (derived; not for override).

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst_n  in  1  asynchronous active-low reset
- i_fifo_rst  in  1  synchronous FIFO flush
- i_wren  in  1  write request
- i_wdata  in  DATA_WIDTH  write data
- i_werr  in  ERR_WIDTH  error bits stored with i_wdata
- i_rden  in  1  read request
- o_rdata  out  DATA_WIDTH  read data
- o_rerr  out  ERR_WIDTH  error bits of the read entry
- o_empty  out  1  FIFO empty
- o_full  out  1  FIFO full
- o_count  out  CW  entries stored, 0..DATA_DEPTH
- i_trig_sel  in  2  trigger level select
- o_trig  out  1  count >= trigger level
- o_overrun  out  1  sticky overrun flag
- i_ovr_clr  in  1  clears o_overrun
- o_err_in_fifo  out  1  at least one stored entry has a nonzero error field

Behaviour:
- Clock and reset: single clock i_sys_clk; reset i_sys_rst_n is asynchronous, active-low.
- Reset values: o_rdata=0, o_rerr=0, o_empty=1, o_full=0, o_count=0, o_trig=0, o_overrun=0, o_err_in_fifo=0. Pointers and the error counter are 0. Memory contents are not reset.
- i_fifo_rst (synchronous, highest priority after reset):
  - Clears pointers, count, error counter and o_overrun.
  - Same-cycle i_wren and i_rden are ignored.
  - o_rdata/o_rerr go to 0 on the next clock.
- Read accept: rd_acc = i_rden & !o_empty.
- Write accept: wr_acc = i_wren & (!o_full | rd_acc). A write while full is accepted if a read is accepted in the same cycle.
- Count update:
  - wr_acc & !rd_acc: o_count+1.
  - rd_acc & !wr_acc: o_count-1.
  - Both or neither: o_count unchanged.
- Pointers: log2(DATA_DEPTH) bits wide; wrap naturally from DATA_DEPTH-1 to 0.
- Flags, decoded combinationally from registered count:
  - o_empty = (o_count==0).
  - o_full = (o_count==DATA_DEPTH).
- Empty + read + write in the same cycle: the read is ignored and the write is accepted.
- FWFT=0 read path: on rd_acc, {o_rerr,o_rdata} load the head entry at the next edge (1-cycle latency). Otherwise they hold their value.
- FWFT=1 read path:
  - {o_rerr,o_rdata} show the head entry combinationally whenever !o_empty, and are forced to 0 when empty.
  - rd_acc pops the head; the next entry is visible after the edge.
  - A written word is visible the cycle after the write edge.
- Trigger level (i_trig_sel):
  - 00 -> 1; 01 -> DATA_DEPTH/4; 10 -> DATA_DEPTH/2; 11 -> DATA_DEPTH-2. At depth 16 this gives 1/4/8/14.
  - o_trig = (o_count >= level), combinational.
  - i_trig_sel may change at any time and takes effect immediately.
- Overrun:
  - o_overrun sets at the edge after a cycle with i_wren & o_full & !rd_acc. The data is dropped and FIFO contents are unchanged.
  - Stays set until i_ovr_clr or i_fifo_rst.
  - Set has priority over a same-cycle i_ovr_clr.
- Error counter (CW bits):
  - +1 on wr_acc with i_werr!=0.
  - -1 on rd_acc when the popped entry's error field !=0.
  - Both in the same cycle: net 0.
  - o_err_in_fifo = (err_cnt!=0).
- Arithmetic: count and err_cnt never exceed DATA_DEPTH and never underflow. Guaranteed by the accept rules; no saturation logic needed.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with i_werr=0 (DATA_DEPTH=16) -> o_full=1, o_count=16.
  - A 17th write 0xAA without read -> o_overrun=1 next cycle, count stays 16.
  - 16 reads return 0x00..0x0F in order; then o_empty=1.
- Full FIFO, i_wren=1 with 0x55 and i_rden=1 in the same cycle -> o_count stays 16, o_overrun stays 0, 0x55 is read out last.
- Trigger: i_trig_sel=01, write 3 entries -> o_trig=0; write a 4th -> o_trig=1.
  - Switch i_trig_sel to 11 -> o_trig=0 immediately; fill to 14 -> o_trig=1.
- Error tracking: write 0x41/err=000, 0x42/err=010, 0x43/err=000 -> o_err_in_fifo=1.
  - After the second read (0x42, o_rerr=010) -> o_err_in_fifo=0.
- FWFT=1: write 0x5A into empty FIFO -> o_rdata=0x5A the cycle after the write with no i_rden.
  - Pop it -> o_rdata=0, o_empty=1.
  - Empty with simultaneous i_wren/i_rden -> count becomes 1.
- Mid-operation: with 5 entries and o_overrun=1, pulse i_fifo_rst with i_wren=1 -> count=0, o_overrun=0, o_empty=1.
  - Assert i_sys_rst_n low asynchronously mid-burst -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/uart_fifo_ctrl_if.sv
// Interface bundling the uart_fifo_ctrl data path, status and control signals.
// master = the UART logic driving the FIFO; slave = the FIFO itself.
interface uart_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_WIDTH  = 3,
  parameter int CW         = 5
);
  logic                  i_fifo_rst;
  logic                  i_wren;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [ERR_WIDTH-1:0]  i_werr;
  logic                  i_rden;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic [ERR_WIDTH-1:0]  o_rerr;
  logic                  o_empty;
  logic                  o_full;
  logic [CW-1:0]         o_count;
  logic [1:0]            i_trig_sel;
  logic                  o_trig;
  logic                  o_overrun;
  logic                  i_ovr_clr;
  logic                  o_err_in_fifo;

  modport master (
    output i_fifo_rst, i_wren, i_wdata, i_werr, i_rden, i_trig_sel, i_ovr_clr,
    input  o_rdata, o_rerr, o_empty, o_full, o_count, o_trig, o_overrun, o_err_in_fifo
  );

  modport slave (
    input  i_fifo_rst, i_wren, i_wdata, i_werr, i_rden, i_trig_sel, i_ovr_clr,
    output o_rdata, o_rerr, o_empty, o_full, o_count, o_trig, o_overrun, o_err_in_fifo
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// UART 16550 data-path FIFO: data plus per-character error bits (parity,
// framing, break), programmable trigger level, sticky overrun, error-in-FIFO
// indicator and a selectable registered / first-word-fall-through read port.
// DATA_DEPTH must be a power of two and at least 8.
module uart_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_WIDTH  = 3,
  parameter int DATA_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int CW         = $clog2(DATA_DEPTH) + 1
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst_n,
  uart_fifo_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int EW = DATA_WIDTH + ERR_WIDTH;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] LVL_ONE  = CW'(1);
  localparam logic [CW-1:0] LVL_QTR  = CW'(DATA_DEPTH / 4);
  localparam logic [CW-1:0] LVL_HALF = CW'(DATA_DEPTH / 2);
  localparam logic [CW-1:0] LVL_HIGH = CW'(DATA_DEPTH - 2);

  logic [EW-1:0] mem [DATA_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, err_cnt, trig_level;
  logic          overrun;
  logic          empty, full;
  logic          rd_acc, wr_acc;
  logic          wr_has_err, rd_has_err;
  logic [EW-1:0] head;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  // A read frees a slot in the same cycle, so a write to a full FIFO is
  // accepted when it is paired with an accepted read.
  assign rd_acc = bus.i_rden & ~empty;
  assign wr_acc = bus.i_wren & (~full | rd_acc);

  assign head       = mem[rd_ptr];
  assign rd_has_err = |head[EW-1:DATA_WIDTH];
  assign wr_has_err = |bus.i_werr;

  // Pointers, occupancy, error-entry count and sticky overrun.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
      overrun <= 1'b0;
    end else if (bus.i_fifo_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      // Power-of-two depth: AW-bit pointers wrap on their own.
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      case ({wr_acc & wr_has_err, rd_acc & rd_has_err})
        2'b10:   err_cnt <= err_cnt + CW'(1);
        2'b01:   err_cnt <= err_cnt - CW'(1);
        default: ;
      endcase

      // Dropped write sets the flag; setting wins over a same-cycle clear.
      if (bus.i_wren & full & ~rd_acc) overrun <= 1'b1;
      else if (bus.i_ovr_clr)          overrun <= 1'b0;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; empty/full bookkeeping guarantees a stale
  // entry is never presented, and a reset would block RAM inference.
  always_ff @(posedge i_sys_clk) begin
    if (wr_acc & ~bus.i_fifo_rst) mem[wr_ptr] <= {bus.i_werr, bus.i_wdata};
  end

  // Trigger threshold decode from the select input.
  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    trig_level = LVL_ONE;
    case (bus.i_trig_sel)
      2'b01:   trig_level = LVL_QTR;
      2'b10:   trig_level = LVL_HALF;
      2'b11:   trig_level = LVL_HIGH;
      default: ;
    endcase
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [EW-1:0] rd_q;

      // Registered read: head entry lands one edge after an accepted read.
      always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n)        rd_q <= '0;
        else if (bus.i_fifo_rst) rd_q <= '0;
        else if (rd_acc)         rd_q <= head;
      end

      assign {bus.o_rerr, bus.o_rdata} = rd_q;
    end else begin : g_fwft_read
      // Head entry shown directly; zero while nothing is stored.
      assign {bus.o_rerr, bus.o_rdata} = empty ? '0 : head;
    end
  endgenerate

  assign bus.o_empty       = empty;
  assign bus.o_full        = full;
  assign bus.o_count       = count;
  assign bus.o_trig        = (count >= trig_level);
  assign bus.o_overrun     = overrun;
  assign bus.o_err_in_fifo = (err_cnt != '0);

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: a registered-read and an FWFT instance driven with
// identical stimulus, checked against a queue-based model of the FIFO contents.
// Registered read data is compared by a scoreboard monitor.
module tb_uart_fifo_ctrl;

  localparam int DW    = 8;
  localparam int EWD   = 3;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  typedef logic [EWD+DW-1:0] ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_ctrl_if #(.DATA_WIDTH(DW), .ERR_WIDTH(EWD), .CW(CW)) bus0 ();
  uart_fifo_ctrl_if #(.DATA_WIDTH(DW), .ERR_WIDTH(EWD), .CW(CW)) bus1 ();

  uart_fifo_ctrl #(.DATA_WIDTH(DW), .ERR_WIDTH(EWD), .DATA_DEPTH(DEPTH), .FWFT(0))
    dut0 (.i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(bus0));
  uart_fifo_ctrl #(.DATA_WIDTH(DW), .ERR_WIDTH(EWD), .DATA_DEPTH(DEPTH), .FWFT(1))
    dut1 (.i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(bus1));

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];      // model of FIFO contents, head at index 0
  ent_t exp_q[$];   // expected registered-read results
  logic m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int level_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 1;
      2'd1:    return DEPTH / 4;
      2'd2:    return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic int model_errs();
    int n = 0;
    foreach (mq[k]) if (mq[k][DW+:EWD] != 0) n++;
    return n;
  endfunction

  task automatic set_sel(input logic [1:0] s);
    bus0.i_trig_sel = s;
    bus1.i_trig_sel = s;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic [2:0] e,
                       input logic r, input logic f, input logic c);
    bus0.i_wren = w; bus0.i_wdata = d; bus0.i_werr = e;
    bus0.i_rden = r; bus0.i_fifo_rst = f; bus0.i_ovr_clr = c;
    bus1.i_wren = w; bus1.i_wdata = d; bus1.i_werr = e;
    bus1.i_rden = r; bus1.i_fifo_rst = f; bus1.i_ovr_clr = c;
  endtask

  // Compare every status output (and the FWFT read port) with the model.
  task automatic check_state();
    ent_t h;
    int   n;
    n = mq.size();
    h = (n != 0) ? mq[0] : '0;
    check("count0",   bus0.o_count, n);
    check("empty0",   bus0.o_empty, n == 0);
    check("full0",    bus0.o_full, n == DEPTH);
    check("trig0",    bus0.o_trig, n >= level_of(bus0.i_trig_sel));
    check("overrun0", bus0.o_overrun, m_ovr);
    check("errfifo0", bus0.o_err_in_fifo, model_errs() != 0);
    check("count1",   bus1.o_count, n);
    check("trig1",    bus1.o_trig, n >= level_of(bus1.i_trig_sel));
    check("overrun1", bus1.o_overrun, m_ovr);
    check("errfifo1", bus1.o_err_in_fifo, model_errs() != 0);
    check("fwft_rdata1", bus1.o_rdata, h[DW-1:0]);
    check("fwft_rerr1",  bus1.o_rerr, h[DW+:EWD]);
  endtask

  task automatic check_reset_values();
    check("rst_rdata0", bus0.o_rdata, 0);  check("rst_rdata1", bus1.o_rdata, 0);
    check("rst_rerr0",  bus0.o_rerr, 0);   check("rst_rerr1",  bus1.o_rerr, 0);
    check("rst_empty0", bus0.o_empty, 1);  check("rst_empty1", bus1.o_empty, 1);
    check("rst_full0",  bus0.o_full, 0);   check("rst_full1",  bus1.o_full, 0);
    check("rst_count0", bus0.o_count, 0);  check("rst_count1", bus1.o_count, 0);
    check("rst_trig0",  bus0.o_trig, 0);   check("rst_trig1",  bus1.o_trig, 0);
    check("rst_ovr0",   bus0.o_overrun, 0); check("rst_ovr1",  bus1.o_overrun, 0);
    check("rst_err0",   bus0.o_err_in_fifo, 0); check("rst_err1", bus1.o_err_in_fifo, 0);
  endtask

  // One clock cycle: apply inputs, advance the model, check after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic [2:0] e,
                      input logic r, input logic f = 1'b0, input logic c = 1'b0);
    bit emp, ful, rd, wr;
    drive(w, d, e, r, f, c);
    emp = (mq.size() == 0);
    ful = (mq.size() == DEPTH);
    rd  = r && !emp;
    wr  = w && (!ful || rd);
    if (f) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      if (rd) exp_q.push_back(mq.pop_front());
      if (wr) mq.push_back({e, d});
      if (w && ful && !rd) m_ovr = 1'b1;
      else if (c)          m_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Scoreboard monitor for the registered read port: a read accepted at an
  // edge must present the expected entry during the following cycle.
  initial begin
    forever begin
      logic fire;
      ent_t x;
      @(posedge clk);
      fire = rst_n && bus0.i_rden && !bus0.o_empty && !bus0.i_fifo_rst;
      @(negedge clk);
      if (fire && rst_n) begin
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("rdata0", bus0.o_rdata, x[DW-1:0]);
          check("rerr0",  bus0.o_rerr, x[DW+:EWD]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pw;
    drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
    set_sel(2'd0);
    #3;
    check_reset_values();
    #9 rst_n = 1'b1;

    // Fill to full, overrun, drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 3'b000, 1'b0);
    check("full_after_16", bus0.o_full, 1);
    check("count_16", bus0.o_count, 16);
    step(1'b1, 8'hAA, 3'b000, 1'b0);
    check("ovr_set", bus0.o_overrun, 1);
    check("ovr_count_16", bus0.o_count, 16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 3'b000, 1'b1);
    check("empty_after_drain", bus0.o_empty, 1);

    // Write accepted while full because of a paired read; set beats clear.
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    check("ovr_cleared", bus0.o_overrun, 0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 3'b000, 1'b0);
    step(1'b1, 8'h55, 3'b000, 1'b1);
    check("full_wr_rd_count", bus0.o_count, 16);
    check("full_wr_rd_ovr", bus0.o_overrun, 0);
    step(1'b1, 8'hBB, 3'b000, 1'b0, 1'b0, 1'b1);
    check("ovr_set_beats_clr", bus0.o_overrun, 1);
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 3'b000, 1'b1);

    // Trigger levels.
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
    set_sel(2'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 3'b000, 1'b0);
    check("trig_q_3", bus0.o_trig, 0);
    step(1'b1, 8'h23, 3'b000, 1'b0);
    check("trig_q_4", bus0.o_trig, 1);
    set_sel(2'd3);
    #1;
    check("trig_sel_immediate0", bus0.o_trig, 0);
    check("trig_sel_immediate1", bus1.o_trig, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h24 + i), 3'b000, 1'b0);
    check("trig_high_14", bus0.o_trig, 1);
    set_sel(2'd0);

    // Error tracking.
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
    step(1'b1, 8'h41, 3'b000, 1'b0);
    step(1'b1, 8'h42, 3'b010, 1'b0);
    step(1'b1, 8'h43, 3'b000, 1'b0);
    check("err_in_fifo_set", bus0.o_err_in_fifo, 1);
    step(1'b0, 8'h00, 3'b000, 1'b1);
    step(1'b0, 8'h00, 3'b000, 1'b1);
    check("err_in_fifo_clear", bus0.o_err_in_fifo, 0);
    step(1'b0, 8'h00, 3'b000, 1'b1);

    // First-word-fall-through behaviour.
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 3'b000, 1'b0);
    check("fwft_visible", bus1.o_rdata, 8'h5A);
    step(1'b0, 8'h00, 3'b000, 1'b1);
    check("fwft_popped_zero", bus1.o_rdata, 0);
    check("fwft_popped_empty", bus1.o_empty, 1);
    step(1'b1, 8'h66, 3'b000, 1'b1);
    check("empty_wr_rd_count", bus1.o_count, 1);

    // Flush in the middle of operation with overrun pending.
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 3'b001, 1'b0);
    step(1'b1, 8'hEE, 3'b000, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 3'b000, 1'b1);
    check("pre_flush_count", bus0.o_count, 5);
    check("pre_flush_ovr", bus0.o_overrun, 1);
    step(1'b1, 8'h77, 3'b000, 1'b0, 1'b1);
    check("flush_count", bus0.o_count, 0);
    check("flush_ovr", bus0.o_overrun, 0);
    check("flush_empty", bus0.o_empty, 1);
    check("flush_rdata", bus0.o_rdata, 0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 3'b100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    exp_q.delete();
    m_ovr = 1'b0;
    check_reset_values();
    drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with phases biased toward filling or draining.
    pw = 50;
    for (int i = 0; i < 600; i++) begin
      logic       w, r, f, c;
      logic [2:0] e;
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       pw = 20;
          1:       pw = 50;
          default: pw = 85;
        endcase
      end
      if ($urandom_range(0, 19) == 0) set_sel(2'($urandom_range(0, 3)));
      w = ($urandom_range(0, 99) < pw);
      r = ($urandom_range(0, 99) < (100 - pw));
      e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      f = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 9) == 0);
      step(w, 8'($urandom), e, r, f, c);
    end

    step(1'b0, 8'h00, 3'b000, 1'b0);
    step(1'b0, 8'h00, 3'b000, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
